// File: rtl/linebuf_pkg.sv
// ---------------------------------------------------------------------------
// linebuf_pkg
// Shared definitions for the 3-line window buffer controller:
//   - lb_state_t : controller sequencing states
//   - tag_op_t   : what a pending buffer shift does to the window tags
//   - common resolution constants
//   - linebuf_cw : width of the frame shift counter for a given resolution
// ---------------------------------------------------------------------------
package linebuf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } lb_state_t;

    // Effect of an accepted shift on the window tags, applied when the
    // buffer actually performs that shift one cycle later.
    typedef enum logic [1:0] {
        TAG_OFF   = 2'd0,  // window not centred on a real pixel
        TAG_START = 2'd1,  // first valid window of the frame, centre (0,0)
        TAG_ADV   = 2'd2,  // next valid window in raster order
        TAG_END   = 2'd3   // final flush shift, frame complete
    } tag_op_t;

    localparam int H_640 = 640;
    localparam int V_480 = 480;
    localparam int H_800 = 800;
    localparam int V_600 = 600;

    // Shift counter must hold H*V source shifts plus 2*H-1 flush shifts.
    function automatic int linebuf_cw(input int h, input int v);
        return $clog2(h * v + 2 * h);
    endfunction

endpackage

// File: rtl/linebuf_ctrl_raster_pos.sv
// ---------------------------------------------------------------------------
// raster_pos
// Enable-driven x/y raster wrap counter with registered border flag.
//   clock   in   clock
//   reset   in   asynchronous active-high reset (all outputs to 0)
//   clr     in   load centre (0,0)
//   en      in   advance one position in raster order (x wraps into y)
//   x       out  current column
//   y       out  current row
//   border  out  1 when (x,y) lies on the first/last row or column
// ---------------------------------------------------------------------------
module raster_pos
    import linebuf_pkg::*;
#(
    parameter int  H  = H_640,
    parameter int  V  = V_480,
    localparam int XW = $clog2(H),
    localparam int YW = $clog2(V)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          border
);

    localparam logic [XW-1:0] X_LAST = XW'(H - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V - 1);

    logic [XW-1:0] x_reg, x_next;
    logic [YW-1:0] y_reg, y_next;
    logic          border_reg, border_next;

    always_comb begin
        x_next      = x_reg;
        y_next      = y_reg;
        border_next = border_reg;
        if (clr) begin
            x_next = '0;
            y_next = '0;
        end else if (en) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                y_next = (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
            end else begin
                x_next = x_reg + XW'(1);
            end
        end
        // Border only follows a real position change so that it stays 0
        // out of reset until the first window is loaded.
        if (clr || en) begin
            border_next = (x_next == '0) || (x_next == X_LAST) ||
                          (y_next == '0) || (y_next == Y_LAST);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_reg      <= '0;
            y_reg      <= '0;
            border_reg <= 1'b0;
        end else begin
            x_reg      <= x_next;
            y_reg      <= y_next;
            border_reg <= border_next;
        end
    end

    assign x      = x_reg;
    assign y      = y_reg;
    assign border = border_reg;

endmodule

// File: rtl/linebuf_ctrl.sv
// ---------------------------------------------------------------------------
// linebuf_ctrl
// Sequencing controller for the 3-line window buffer of the edge detector.
// Accepts source pixels, drives the buffer clock-enable / fill select one
// cycle later, and tags each buffer window with validity and centre position.
//   clock       in   pixel clock
//   reset       in   asynchronous active-high reset
//   iValid      in   source pixel present
//   iSOF        in   start of frame (with iValid marks pixel 0)
//   iStall      in   downstream busy, freeze everything
//   oClken      out  registered buffer clock-enable
//   oFillSel    out  1 = buffer shifts in zero (flush), 0 = source pixel
//   oGridValid  out  window is centred on a real pixel
//   oBorder     out  centre lies on an outer row or column
//   oX, oY      out  window centre column / row
//   oBusy       out  controller not idle
//   oFrameDone  out  one-cycle pulse after the last window of the frame
//   oSofErr     out  one-cycle pulse on a start-of-frame inside a frame
// ---------------------------------------------------------------------------
module linebuf_ctrl
    import linebuf_pkg::*;
#(
    parameter int  H_ACTIVE = H_640,
    parameter int  V_ACTIVE = V_480,
    parameter int  CW       = linebuf_cw(H_ACTIVE, V_ACTIVE),
    localparam int XW       = $clog2(H_ACTIVE),
    localparam int YW       = $clog2(V_ACTIVE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iValid,
    input  logic          iSOF,
    input  logic          iStall,
    output logic          oClken,
    output logic          oFillSel,
    output logic          oGridValid,
    output logic          oBorder,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic          oBusy,
    output logic          oFrameDone,
    output logic          oSofErr
);

    // Shift-count landmarks: first valid window, last source pixel,
    // final flush shift (its window is one past the last pixel).
    localparam logic [CW-1:0] N_PRIMED   = CW'(2 * H_ACTIVE - 1);
    localparam logic [CW-1:0] N_LAST_SRC = CW'(H_ACTIVE * V_ACTIVE);
    localparam logic [CW-1:0] N_FLUSHED  = CW'(H_ACTIVE * V_ACTIVE + 2 * H_ACTIVE - 1);

    lb_state_t     state_reg, state_next;
    logic [CW-1:0] n_reg, n_next;
    logic          shift_next, fill_next, sof_err_next;
    tag_op_t       tag_reg, tag_next;

    logic          clken_reg, fill_reg, sof_err_reg;
    logic          grid_valid_reg, frame_done_reg;
    logic          sof;
    logic          pos_clr, pos_en;

    assign sof = iValid & iSOF;

    // -----------------------------------------------------------------------
    // Accept decision and next state. A stall blocks everything, including
    // a start of frame, so the buffer and tags stay exactly where they are.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        n_next       = n_reg;
        shift_next   = 1'b0;
        fill_next    = 1'b0;
        sof_err_next = 1'b0;
        if (!iStall) begin
            if (sof) begin
                // A new frame always restarts priming with this pixel as 0.
                shift_next   = 1'b1;
                n_next       = CW'(1);
                state_next   = PRIME;
                sof_err_next = (state_reg != IDLE);
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        // Pixels outside a frame are dropped.
                    end
                    PRIME: begin
                        if (iValid) begin
                            shift_next = 1'b1;
                            n_next     = n_reg + CW'(1);
                            if (n_next == N_PRIMED) state_next = RUN;
                        end
                    end
                    RUN: begin
                        if (iValid) begin
                            shift_next = 1'b1;
                            n_next     = n_reg + CW'(1);
                            if (n_next == N_LAST_SRC) state_next = FLUSH;
                        end
                    end
                    FLUSH: begin
                        // Source is in blanking; push zeros regardless of iValid.
                        shift_next = 1'b1;
                        fill_next  = 1'b1;
                        n_next     = n_reg + CW'(1);
                        if (n_next == N_FLUSHED) state_next = IDLE;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Classify the window produced by the shift being accepted.
    always_comb begin
        if (n_next == N_PRIMED) begin
            tag_next = TAG_START;
        end else if (n_next == N_FLUSHED) begin
            tag_next = TAG_END;
        end else if ((n_next > N_PRIMED) && (n_next < N_FLUSHED)) begin
            tag_next = TAG_ADV;
        end else begin
            tag_next = TAG_OFF;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            n_reg       <= '0;
            clken_reg   <= 1'b0;
            fill_reg    <= 1'b0;
            sof_err_reg <= 1'b0;
            tag_reg     <= TAG_OFF;
        end else begin
            state_reg   <= state_next;
            n_reg       <= n_next;
            clken_reg   <= shift_next;
            fill_reg    <= fill_next;
            sof_err_reg <= sof_err_next;
            if (shift_next) tag_reg <= tag_next;
        end
    end

    // -----------------------------------------------------------------------
    // Window tags follow the buffer: they change on the edge where the
    // buffer shifts (clken_reg high), so they line up with its taps.
    // -----------------------------------------------------------------------
    assign pos_clr = clken_reg && (tag_reg == TAG_START);
    assign pos_en  = clken_reg && (tag_reg == TAG_ADV);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grid_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= clken_reg && (tag_reg == TAG_END);
            if (sof_err_next) begin
                // The window in flight belongs to an abandoned frame.
                grid_valid_reg <= 1'b0;
            end else if (clken_reg) begin
                grid_valid_reg <= (tag_reg == TAG_START) || (tag_reg == TAG_ADV);
            end
        end
    end

    raster_pos #(
        .H (H_ACTIVE),
        .V (V_ACTIVE)
    ) u_raster_pos (
        .clock  (clock),
        .reset  (reset),
        .clr    (pos_clr),
        .en     (pos_en),
        .x      (oX),
        .y      (oY),
        .border (oBorder)
    );

    assign oClken     = clken_reg;
    assign oFillSel   = fill_reg;
    assign oGridValid = grid_valid_reg;
    assign oBusy      = (state_reg != IDLE);
    assign oFrameDone = frame_done_reg;
    assign oSofErr    = sof_err_reg;

endmodule

// File: tb/tb_linebuf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_linebuf_ctrl
// Directed bench for linebuf_ctrl on an 8x4 frame. A negedge monitor checks
// every new valid window against a raster-order model of the centre.
// ---------------------------------------------------------------------------
module tb_linebuf_ctrl;

    localparam int H = 8;
    localparam int V = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       iValid, iSOF, iStall;
    logic       oClken, oFillSel, oGridValid, oBorder, oBusy, oFrameDone, oSofErr;
    logic [2:0] oX;
    logic [1:0] oY;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    linebuf_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iValid     (iValid),
        .iSOF       (iSOF),
        .iStall     (iStall),
        .oClken     (oClken),
        .oFillSel   (oFillSel),
        .oGridValid (oGridValid),
        .oBorder    (oBorder),
        .oX         (oX),
        .oY         (oY),
        .oBusy      (oBusy),
        .oFrameDone (oFrameDone),
        .oSofErr    (oSofErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_clken"},  oClken,     0);
        chk({pfx, "_fill"},   oFillSel,   0);
        chk({pfx, "_gv"},     oGridValid, 0);
        chk({pfx, "_border"}, oBorder,    0);
        chk({pfx, "_x"},      oX,         0);
        chk({pfx, "_y"},      oY,         0);
        chk({pfx, "_busy"},   oBusy,      0);
        chk({pfx, "_done"},   oFrameDone, 0);
        chk({pfx, "_soferr"}, oSofErr,    0);
    endtask

    // ---------------- window monitor (raster-order model) ----------------
    int   win_count    = 0;
    int   border_count = 0;
    int   idx          = 0;
    logic clken_prev   = 1'b0;
    logic gv_prev      = 1'b0;
    logic valid_at_edge = 1'b0;
    logic toggle_mode  = 1'b0;

    always @(posedge clock) valid_at_edge <= iValid;

    always @(negedge clock) begin
        if (!reset && clken_prev && oGridValid) begin
            if (!gv_prev) idx = 0;
            chk("win_x", oX, idx % H);
            chk("win_y", oY, idx / H);
            chk("win_border", oBorder,
                ((idx % H) == 0 || (idx % H) == H - 1 || (idx / H) == 0 || (idx / H) == V - 1) ? 1 : 0);
            win_count++;
            if (oBorder) border_count++;
            idx++;
        end
        if (toggle_mode && oClken && !oFillSel) chk("clken_only_after_valid", valid_at_edge, 1);
        clken_prev = oClken;
        gv_prev    = oGridValid;
    end

    // Bounded wait over the flush tail; counts done pulses and zero-fill shifts.
    task automatic wait_done(output int pulses, output int first_at, output int fills);
        pulses   = 0;
        first_at = -1;
        fills    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (oFrameDone) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
            if (oClken && oFillSel) fills++;
        end
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w0, b0, pulses, done_at, fills, k;
        reset  = 1'b1;
        iValid = 1'b0;
        iSOF   = 1'b0;
        iStall = 1'b0;
        @(negedge clock);
        chk_all_zero("reset");
        @(posedge clock);
        #1 reset = 1'b0;

        // Frame 1: continuous pixels, no stall.
        w0 = win_count;
        b0 = border_count;
        for (int j = 0; j < 32; j++) begin
            iValid = 1'b1;
            iSOF   = (j == 0);
            @(negedge clock);
            if (j == 15) chk("f1_gv_before_threshold", oGridValid, 0);
            if (j == 16) begin
                chk("f1_first_gv", oGridValid, 1);
                chk("f1_first_x", oX, 0);
                chk("f1_first_y", oY, 0);
                chk("f1_first_border", oBorder, 1);
            end
            @(posedge clock);
            #1;
        end
        iValid = 1'b0;
        iSOF   = 1'b0;
        wait_done(pulses, done_at, fills);
        chk("f1_done_pulses", pulses, 1);
        chk("f1_done_at", done_at, 16);
        chk("f1_flush_shifts", fills, 15);
        chk("f1_windows", win_count - w0, 32);
        chk("f1_border_windows", border_count - b0, 20);
        chk("f1_idle_busy", oBusy, 0);
        chk("f1_idle_gv", oGridValid, 0);
        $display("frame1 continuous: windows=%0d border=%0d done_at=%0d", win_count - w0, border_count - b0, done_at);

        // Frame 2: iValid toggling every cycle.
        w0 = win_count;
        b0 = border_count;
        toggle_mode = 1'b1;
        for (int j = 0; j < 64; j++) begin
            iValid = (j % 2 == 0);
            iSOF   = (j == 0);
            @(posedge clock);
            #1;
        end
        iValid = 1'b0;
        iSOF   = 1'b0;
        wait_done(pulses, done_at, fills);
        toggle_mode = 1'b0;
        chk("f2_done_pulses", pulses, 1);
        chk("f2_flush_shifts", fills, 15);
        chk("f2_windows", win_count - w0, 32);
        chk("f2_border_windows", border_count - b0, 20);
        $display("frame2 toggled: windows=%0d border=%0d", win_count - w0, border_count - b0);

        // Frame 3: stall for 5 cycles while the window sits on (3,1).
        w0 = win_count;
        k  = 0;
        for (int j = 0; j < 40; j++) begin
            iValid = (k < 32);
            iSOF   = (k == 0);
            iStall = (j >= 26 && j <= 30);
            @(negedge clock);
            if (j >= 27 && j <= 31) begin
                chk("f3_stall_clken", oClken, 0);
                chk("f3_stall_x", oX, 3);
                chk("f3_stall_y", oY, 1);
                chk("f3_stall_gv", oGridValid, 1);
            end
            if (j == 33) begin
                chk("f3_resume_x", oX, 4);
                chk("f3_resume_y", oY, 1);
            end
            @(posedge clock);
            #1;
            if (iValid && !iStall) k++;
        end
        iValid = 1'b0;
        iSOF   = 1'b0;
        iStall = 1'b0;
        wait_done(pulses, done_at, fills);
        chk("f3_done_pulses", pulses, 1);
        chk("f3_windows", win_count - w0, 32);
        $display("frame3 stall: windows=%0d", win_count - w0);

        // Frame 4: unexpected start of frame at raster pixel 20.
        w0 = win_count;
        for (int j = 0; j < 52; j++) begin
            iValid = 1'b1;
            iSOF   = (j == 0 || j == 20);
            @(negedge clock);
            if (j == 20) begin
                chk("f4_gv_before_sof", oGridValid, 1);
                chk("f4_soferr_before", oSofErr, 0);
            end
            if (j == 21) begin
                chk("f4_soferr_pulse", oSofErr, 1);
                chk("f4_gv_dropped", oGridValid, 0);
                chk("f4_busy", oBusy, 1);
                chk("f4_fill", oFillSel, 0);
            end
            if (j == 22) begin
                chk("f4_soferr_single", oSofErr, 0);
                chk("f4_gv_still_low", oGridValid, 0);
            end
            if (j == 35) chk("f4_gv_before_reprime", oGridValid, 0);
            if (j == 36) begin
                chk("f4_reprime_gv", oGridValid, 1);
                chk("f4_reprime_x", oX, 0);
                chk("f4_reprime_y", oY, 0);
            end
            @(posedge clock);
            #1;
        end
        iValid = 1'b0;
        iSOF   = 1'b0;
        wait_done(pulses, done_at, fills);
        chk("f4_done_pulses", pulses, 1);
        chk("f4_windows", win_count - w0, 37);
        $display("frame4 sof error: windows=%0d", win_count - w0);

        // Frame 5: asynchronous reset in the middle of the flush.
        for (int j = 0; j < 32; j++) begin
            iValid = 1'b1;
            iSOF   = (j == 0);
            @(posedge clock);
            #1;
        end
        iValid = 1'b0;
        iSOF   = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("f5_in_flush_busy", oBusy, 1);
        chk("f5_in_flush_fill", oFillSel, 1);
        chk("f5_in_flush_gv", oGridValid, 1);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("f5_async_reset");
        @(posedge clock);
        #1 reset = 1'b0;
        for (int j = 0; j < 8; j++) begin
            iValid = 1'b1;
            iSOF   = 1'b0;
            @(negedge clock);
            chk("f5_idle_busy", oBusy, 0);
            chk("f5_idle_clken", oClken, 0);
            @(posedge clock);
            #1;
        end
        iValid = 1'b1;
        iSOF   = 1'b1;
        @(posedge clock);
        #1;
        iValid = 1'b0;
        iSOF   = 1'b0;
        @(negedge clock);
        chk("f5_restart_busy", oBusy, 1);
        chk("f5_restart_clken", oClken, 1);
        $display("frame5 reset mid-flush: restart busy=%0d", oBusy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/linebuf_ctrl.md
# linebuf_ctrl

Sequencing controller for the 3-line window buffer in the edge-detection path. Sits between the VGA pixel source and the buffer:
- Drives the buffer's clock-enable and fill select.
- Tracks raster position through a frame, priming then running then flushing.
- Tags every 3×3 window with validity, centre coordinates and a border flag for the edge detector.

## Interface
- H_ACTIVE, 640: pixels per line; must equal the buffer line depth.
- V_ACTIVE, 480: lines per frame.
- CW, $clog2(H_ACTIVE*V_ACTIVE+2*H_ACTIVE): shift-counter width.
- clock  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- iValid  in  1  input pixel present this cycle.
- iSOF  in  1  start of frame; qualified by iValid and marks pixel 0.
- iStall  in  1  downstream cannot accept a window; freezes the buffer.
- oClken  out  1  clock-enable to the line buffer (registered).
- oFillSel  out  1  1 = buffer shiftin takes constant zero (flush fill); 0 = takes source pixel.
- oGridValid  out  1  buffer window is centred on a real pixel.
- oBorder  out  1  centre lies on row 0, row V_ACTIVE-1, column 0 or column H_ACTIVE-1.
- oX  out  $clog2(H_ACTIVE)  centre column.
- oY  out  $clog2(V_ACTIVE)  centre row.
- oBusy  out  1  state is not IDLE.
- oFrameDone  out  1  one-cycle pulse after the last window of the frame.
- oSofErr  out  1  one-cycle pulse when iSOF arrives mid-frame.

## Operation
- Shift count n = number of buffer shifts since frame start.
- Window centre corresponds to raster pixel p = n − (2·H_ACTIVE − 1).
- Window is valid for 0 ≤ p < H_ACTIVE·V_ACTIVE.
- States:
  - IDLE: oClken = 0. On iValid & iSOF, go to PRIME and shift pixel 0 (n := 1).
  - PRIME: shift on iValid & ~iStall. When n reaches 2·H_ACTIVE − 1, go to RUN with oGridValid = 1 for centre (0,0).
  - RUN: shift on iValid & ~iStall. After shift number H_ACTIVE·V_ACTIVE (last source pixel) is accepted, go to FLUSH.
  - FLUSH: oFillSel = 1. Shift on ~iStall regardless of iValid until n = H_ACTIVE·V_ACTIVE + 2·H_ACTIVE − 1. Then pulse oFrameDone and go to IDLE.
- Centre position:
  - oX/oY start at 0,0 when the window first becomes valid.
  - They advance raster-order on each shift while valid: oX wraps at H_ACTIVE−1 → 0 with oY+1.
- oBorder is computed from the next oX/oY and registered with them.
- iValid & ~iSOF in IDLE: pixel ignored, no shift.
- iValid during FLUSH: ignored; the source must be in blanking.
- iSOF (with iValid) in PRIME/RUN/FLUSH:
  - Pulse oSofErr.
  - Drop oGridValid.
  - Restart at n := 1 in PRIME, shifting that pixel as pixel 0.
- iStall = 1 in any state: oClken = 0, no counter or output changes. oGridValid holds its value; the window stays static.
- Reset (asynchronous, any time): state IDLE. All outputs 0: oClken, oFillSel, oGridValid, oBorder, oX, oY, oBusy, oFrameDone, oSofErr. Buffer contents are not cleared; PRIME overwrites them.

## Timing
- oClken is registered and combinationally decided from the current state and inputs. The buffer therefore shifts one cycle after the controller accepts a pixel.
- Source pixel data is delayed one stage to match oClken.
- oGridValid, oX, oY and oBorder update on the cycle following the shift edge. This aligns with the buffer's combinational window taps.
- Latency from pixel p accepted to the window centred on p: 2·H_ACTIVE − 1 accepted shifts, plus 1 cycle.
- Throughput: one window per cycle when iValid = 1 and iStall = 0.
- oFrameDone asserts one cycle after the final flush shift and is high for exactly one cycle.

## Structure
- Shared package linebuf_pkg holds:
  - The state enum (IDLE, PRIME, RUN, FLUSH).
  - Resolution constants H_640 = 640, V_480 = 480, H_800 = 800, V_600 = 600.
  - A function returning CW.
- One sub-module, raster_pos: an enable-driven x/y wrap counter with border compare, used for oX/oY/oBorder.
- The shift counter and FSM stay in the top level.

## Test plan
- H=8, V=4, continuous iValid, no stall:
  - Window valid threshold is shift 15, so oGridValid first rises 1 cycle after the 15th buffer shift, with oX=0, oY=0, oBorder=1.
  - FLUSH runs 15 shifts after shift 32; oFrameDone pulses once; exactly 32 valid windows are counted.
- Same frame with iValid toggling 1/0 every cycle:
  - Window count is still 32, with raster order and coordinates unchanged.
  - oClken never asserts on an iValid=0 cycle during RUN.
- iStall held for 5 cycles mid-RUN at centre (3,1):
  - oClken=0 for those 5 cycles; oX=3, oY=1 and oGridValid=1 frozen.
  - Resumes at (4,1).
- iSOF at raster pixel 20 of frame:
  - oSofErr pulses, oGridValid drops, state returns to PRIME.
  - The next valid window is centred on (0,0) after 15 further shifts.
- Reset asserted mid-FLUSH:
  - All outputs read 0 in the same cycle (asynchronous).
  - After release the block stays IDLE until iValid & iSOF.
- Border check over the full 8×4 frame: oBorder=1 for exactly 20 of the 32 windows (rows 0, 3 and columns 0, 7).
